// File: rtl/pc_branch_pkg.sv
// Shared types and constants for the program-counter / branch-resolution unit.
// The FSM encoding is shared between the RTL and anything that inspects the unit.
package pc_branch_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_TRAP = 2'd2
  } pc_state_t;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned XLEN        = 32;

  // A word-sized instruction must start on a 4-byte boundary
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_branch_unit_next_pc_calc.sv
// Combinational next-PC selection with priority jalr > jal > taken branch > sequential.
// Zero latency; flags a misaligned target only on a taken control transfer.
module next_pc_calc
  import pc_branch_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic            branch_i,
  input  logic            jal_i,
  input  logic            jalr_i,
  input  logic            flag_i,
  input  logic [XLEN-1:0] imm_b_i,
  input  logic [XLEN-1:0] imm_j_i,
  input  logic [XLEN-1:0] imm_i_i,
  input  logic [XLEN-1:0] rs1_i,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [XLEN-1:0] next_pc_o,
  output logic            misaligned_o
);

  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] jalr_tgt;
  logic [XLEN-1:0] jal_tgt;
  logic [XLEN-1:0] br_tgt;
  logic            taken;

  always_comb begin
    pc_plus4_o = pc_i + XLEN'(INSTR_BYTES);
    jalr_sum   = rs1_i + imm_i_i;
    jalr_tgt   = {jalr_sum[XLEN-1:1], 1'b0};
    jal_tgt    = pc_i + imm_j_i;
    br_tgt     = pc_i + imm_b_i;
  end

  always_comb begin
    next_pc_o = pc_plus4_o;
    taken     = 1'b0;
    if (jalr_i) begin
      next_pc_o = jalr_tgt;
      taken     = 1'b1;
    end else if (jal_i) begin
      next_pc_o = jal_tgt;
      taken     = 1'b1;
    end else if (branch_i && flag_i) begin
      next_pc_o = br_tgt;
      taken     = 1'b1;
    end
    // The sequential path is always aligned given an aligned PC, so it never traps
    misaligned_o = taken && is_misaligned(next_pc_o);
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Holds the PC, issues fetches and resolves branches; traps misaligned targets to TRAP_VEC.
// Retire is combinational on imem_ready_i & ~stall_i in S_RUN; stall holds PC and instret.
module pc_branch_unit
  import pc_branch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC   = 32'h0000_0100
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        branch_i,
  input  logic        jal_i,
  input  logic        jalr_i,
  input  logic        flag_i,
  input  logic [31:0] imm_b_i,
  input  logic [31:0] imm_j_i,
  input  logic [31:0] imm_i_i,
  input  logic [31:0] rs1_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        retire_o,
  output logic        trap_o,
  output logic [31:0] mtval_o,
  output logic [63:0] instret_o
);

  pc_state_t   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] mtval_q, mtval_d;
  logic [63:0] instret_q, instret_d;

  logic [31:0] next_pc;
  logic [31:0] pc_plus4;
  logic        misaligned;
  logic        accept;

  next_pc_calc u_next_pc_calc (
    .pc_i         (pc_q),
    .branch_i     (branch_i),
    .jal_i        (jal_i),
    .jalr_i       (jalr_i),
    .flag_i       (flag_i),
    .imm_b_i      (imm_b_i),
    .imm_j_i      (imm_j_i),
    .imm_i_i      (imm_i_i),
    .rs1_i        (rs1_i),
    .pc_plus4_o   (pc_plus4),
    .next_pc_o    (next_pc),
    .misaligned_o (misaligned)
  );

  assign accept = imem_ready_i & ~stall_i;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mtval_d    = mtval_q;
    instret_d  = instret_q;
    imem_req_o = 1'b0;
    retire_o   = 1'b0;
    trap_o     = 1'b0;

    unique case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        imem_req_o = 1'b1;
        if (accept) begin
          if (misaligned) begin
            pc_d    = TRAP_VEC;
            mtval_d = next_pc;
            state_d = S_TRAP;
          end else begin
            retire_o  = 1'b1;
            pc_d      = next_pc;
            instret_d = instret_q + 64'd1;
          end
        end
      end
      S_TRAP: begin
        trap_o  = 1'b1;
        state_d = S_RUN;
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_BOOT;
      pc_q      <= RESET_ADDR;
      mtval_q   <= 32'h0;
      instret_q <= 64'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      mtval_q   <= mtval_d;
      instret_q <= instret_d;
    end
  end

  assign pc_o        = pc_q;
  assign imem_addr_o = pc_q;
  assign pc_plus4_o  = pc_plus4;
  assign mtval_o     = mtval_q;
  assign instret_o   = instret_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: reset, sequential fetch, branches, jal/jalr, traps, stall, wrap.
module tb_pc_branch_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        stall_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic        branch_i, jal_i, jalr_i, flag_i;
  logic [31:0] imm_b_i, imm_j_i, imm_i_i, rs1_i;
  logic [31:0] pc_o, pc_plus4_o, mtval_o;
  logic        retire_o, trap_o;
  logic [63:0] instret_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  pc_branch_unit #(
    .RESET_ADDR (32'h0000_0000),
    .TRAP_VEC   (32'h0000_0100)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .stall_i      (stall_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ready_i (imem_ready_i),
    .branch_i     (branch_i),
    .jal_i        (jal_i),
    .jalr_i       (jalr_i),
    .flag_i       (flag_i),
    .imm_b_i      (imm_b_i),
    .imm_j_i      (imm_j_i),
    .imm_i_i      (imm_i_i),
    .rs1_i        (rs1_i),
    .pc_o         (pc_o),
    .pc_plus4_o   (pc_plus4_o),
    .retire_o     (retire_o),
    .trap_o       (trap_o),
    .mtval_o      (mtval_o),
    .instret_o    (instret_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0; stall_i = 1'b0; imem_ready_i = 1'b0;
    branch_i = 1'b0; jal_i = 1'b0; jalr_i = 1'b0; flag_i = 1'b0;
    imm_b_i = '0; imm_j_i = '0; imm_i_i = '0; rs1_i = '0;

    tick(); tick();
    chk("rst_pc", pc_o, 64'h0);
    chk("rst_req", imem_req_o, 1'b0);
    chk("rst_retire", retire_o, 1'b0);
    chk("rst_trap", trap_o, 1'b0);
    chk("rst_instret", instret_o, 64'd0);
    chk("rst_mtval", mtval_o, 64'h0);

    rst_ni = 1'b1;
    #1 chk("boot_req", imem_req_o, 1'b0);
    tick();
    chk("run_req", imem_req_o, 1'b1);
    chk("run_addr", imem_addr_o, 64'h0);
    chk("run_instret", instret_o, 64'd0);

    imem_ready_i = 1'b1;
    #1 chk("seq_retire", retire_o, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("seq_pc", pc_o, 64'(4 * i));
    end
    chk("seq_instret", instret_o, 64'd4);

    jal_i = 1'b1; branch_i = 1'b1; flag_i = 1'b1; imm_j_i = 32'h40; imm_b_i = 32'h80;
    tick();
    chk("prio_jal_pc", pc_o, 64'h50);
    chk("prio_instret", instret_o, 64'd5);

    branch_i = 1'b0; flag_i = 1'b0; imm_j_i = 32'hFFFF_FFD0;
    tick();
    chk("jal_back_pc", pc_o, 64'h20);

    jal_i = 1'b0; branch_i = 1'b1; flag_i = 1'b1; imm_b_i = 32'hFFFF_FFF8;
    tick();
    chk("br_taken_pc", pc_o, 64'h18);

    branch_i = 1'b0; flag_i = 1'b0; jal_i = 1'b1; imm_j_i = 32'h8;
    tick();
    chk("jal_fwd_pc", pc_o, 64'h20);

    jal_i = 1'b0; branch_i = 1'b1; flag_i = 1'b0;
    tick();
    chk("br_nt_pc", pc_o, 64'h24);
    chk("br_nt_plus4", pc_plus4_o, 64'h28);
    chk("br_nt_instret", instret_o, 64'd9);

    branch_i = 1'b0; jalr_i = 1'b1; rs1_i = 32'h101; imm_i_i = 32'h0;
    tick();
    chk("jalr_bit0_pc", pc_o, 64'h100);
    chk("jalr_bit0_trap", trap_o, 1'b0);
    chk("jalr_bit0_instret", instret_o, 64'd10);

    rs1_i = 32'h102;
    #1 chk("jalr_mis_retire", retire_o, 1'b0);
    tick();
    chk("trap_pulse", trap_o, 1'b1);
    chk("trap_mtval", mtval_o, 64'h102);
    chk("trap_pc", pc_o, 64'h100);
    chk("trap_instret", instret_o, 64'd10);
    chk("trap_req", imem_req_o, 1'b0);
    chk("trap_retire", retire_o, 1'b0);

    jalr_i = 1'b0;
    tick();
    chk("post_trap_pulse", trap_o, 1'b0);
    chk("post_trap_req", imem_req_o, 1'b1);
    chk("post_trap_instret", instret_o, 64'd10);

    jal_i = 1'b1; imm_j_i = 32'h6;
    tick();
    chk("jal_mis_trap", trap_o, 1'b1);
    chk("jal_mis_mtval", mtval_o, 64'h106);
    chk("jal_mis_pc", pc_o, 64'h100);

    jal_i = 1'b0;
    tick();
    tick();
    chk("seq_after_trap_pc", pc_o, 64'h104);
    chk("seq_after_trap_instret", instret_o, 64'd11);
    chk("mtval_hold", mtval_o, 64'h106);

    imem_ready_i = 1'b0;
    #1 chk("notready_retire", retire_o, 1'b0);
    tick();
    chk("notready_pc", pc_o, 64'h104);

    imem_ready_i = 1'b1; stall_i = 1'b1;
    #1 chk("stall_retire", retire_o, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", pc_o, 64'h104);
      chk("stall_instret", instret_o, 64'd11);
    end

    rst_ni = 1'b0;
    tick();
    chk("stall_rst_pc", pc_o, 64'h0);
    chk("stall_rst_instret", instret_o, 64'd0);
    chk("stall_rst_mtval", mtval_o, 64'h0);
    chk("stall_rst_req", imem_req_o, 1'b0);

    rst_ni = 1'b1; stall_i = 1'b0;
    tick();
    jalr_i = 1'b1; rs1_i = 32'hFFFF_FFFC; imm_i_i = 32'h0;
    tick();
    chk("wrap_hi_pc", pc_o, 64'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4_o, 64'h0);
    jalr_i = 1'b0;
    tick();
    chk("wrap_pc", pc_o, 64'h0);
    chk("wrap_trap", trap_o, 1'b0);
    chk("wrap_instret", instret_o, 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
